// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and elaboration-time helpers for the iterative FFT core
package fft_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} fft_state_e;

  localparam real PI = 3.141592653589793;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bitrev(input int k, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // cos/sin(2*pi*t/n) in Q1.(w-1); +1.0 clamps to the largest positive code
  function automatic int twiddle_q(input int t, input int n, input int w, input bit is_sin);
    real ang, v;
    int  q;
    ang = 2.0 * PI * t / n;
    v   = is_sin ? $sin(ang) : $cos(ang);
    q   = $rtoi($floor(v * real'(longint'(1) << (w - 1)) + 0.5));
    if (q > (1 << (w - 1)) - 1) q = (1 << (w - 1)) - 1;
    return q;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - registered radix-2 DIT butterfly with rounding, scaling and saturation
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int SCALE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                inv,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  input  logic signed [W-1:0] w_cos,
  input  logic signed [W-1:0] w_sin,
  output logic signed [W-1:0] y0_re,
  output logic signed [W-1:0] y0_im,
  output logic signed [W-1:0] y1_re,
  output logic signed [W-1:0] y1_im
);

  localparam int PW = 2 * W + 1;
  localparam int SW = W + 3;
  localparam logic signed [PW-1:0] RND  = PW'(1 << (W - 2));
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  logic signed [PW-1:0] cr_x, ci_x, wr_x, wi_x, prod_re, prod_im, rnd_re, rnd_im;
  logic signed [SW-1:0] t_re, t_im, a_re_x, a_im_x, s0_re, s0_im, s1_re, s1_im;

  function automatic logic signed [W-1:0] post(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] v;
    v = (SCALE != 0) ? ((s + SW'(1)) >>> 1) : s;
    if (v > MAXV) return MAXV[W-1:0];
    if (v < MINV) return MINV[W-1:0];
    return v[W-1:0];
  endfunction

  // Inverse transform uses the conjugate twiddle: W = cos + j*sin instead of cos - j*sin
  always_comb begin
    cr_x    = PW'(c_re);
    ci_x    = PW'(c_im);
    wr_x    = PW'(w_cos);
    wi_x    = inv ? PW'(w_sin) : -PW'(w_sin);
    prod_re = cr_x * wr_x - ci_x * wi_x;
    prod_im = cr_x * wi_x + ci_x * wr_x;
    rnd_re  = (prod_re + RND) >>> (W - 1);
    rnd_im  = (prod_im + RND) >>> (W - 1);
    t_re    = rnd_re[SW-1:0];
    t_im    = rnd_im[SW-1:0];
    a_re_x  = SW'(a_re);
    a_im_x  = SW'(a_im);
    s0_re   = a_re_x + t_re;
    s0_im   = a_im_x + t_im;
    s1_re   = a_re_x - t_re;
    s1_im   = a_im_x - t_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_re <= '0;
      y0_im <= '0;
      y1_re <= '0;
      y1_im <= '0;
    end else if (en) begin
      y0_re <= post(s0_re);
      y0_im <= post(s0_im);
      y1_re <= post(s1_re);
      y1_im <= post(s1_im);
    end
  end

endmodule

// File: rtl/fft_radix2_iter.sv
// rtl/fft_radix2_iter.sv - iterative in-place radix-2 DIT FFT/IFFT with streaming load and unload
module fft_radix2_iter
  import fft_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int SCALE = 1,
  localparam int IW   = idx_width(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [IW-1:0]       out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam int LOGN = IW;
  localparam int HALF = N / 2;
  localparam int SW   = idx_width(LOGN);
  localparam int TW   = IW - 1;
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  fft_state_e state, state_nx;

  logic [IW-1:0] io_cnt, bfly_cnt;
  logic [SW-1:0] stage_cnt;
  logic          inv_r;

  logic signed [W-1:0] buf_re [N];
  logic signed [W-1:0] buf_im [N];
  logic signed [W-1:0] rom_cos [HALF];
  logic signed [W-1:0] rom_sin [HALF];

  logic          load_fire, out_fire, issue, stage_end, last_stage;
  logic [IW-1:0] mask, addr_a, addr_c;
  logic [TW-1:0] tw_idx;
  logic          wb_valid;
  logic [IW-1:0] wb_a, wb_c;
  logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im;

  for (genvar t = 0; t < HALF; t++) begin : g_rom
    assign rom_cos[t] = W'(twiddle_q(t, N, W, 1'b0));
    assign rom_sin[t] = W'(twiddle_q(t, N, W, 1'b1));
  end

  // bfly_cnt == HALF is the stall slot that lets the last write-back land before the next stage reads
  always_comb begin
    load_fire  = (state == LOAD) && in_valid;
    out_fire   = (state == UNLOAD) && out_ready;
    issue      = (state == COMPUTE) && (bfly_cnt < IW'(HALF));
    stage_end  = (state == COMPUTE) && (bfly_cnt == IW'(HALF));
    last_stage = (stage_cnt == SW'(LOGN - 1));
    mask       = (ONE << stage_cnt) - ONE;
    addr_a     = ((bfly_cnt & ~mask) << 1) | (bfly_cnt & mask);
    addr_c     = addr_a | (ONE << stage_cnt);
    tw_idx     = TW'((bfly_cnt & mask) << (IW'(LOGN - 1) - IW'(stage_cnt)));
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_fire && io_cnt == LAST) state_nx = COMPUTE;
      COMPUTE: if (stage_end && last_stage) state_nx = UNLOAD;
      UNLOAD:  if (out_fire && io_cnt == LAST) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    busy      = (state != LOAD);
    out_valid = (state == UNLOAD);
    out_re    = out_valid ? buf_re[io_cnt] : '0;
    out_im    = out_valid ? buf_im[io_cnt] : '0;
    out_idx   = out_valid ? io_cnt : '0;
    out_last  = out_valid && (io_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      io_cnt    <= '0;
      bfly_cnt  <= '0;
      stage_cnt <= '0;
      inv_r     <= 1'b0;
      wb_valid  <= 1'b0;
      wb_a      <= '0;
      wb_c      <= '0;
    end else begin
      state <= state_nx;
      if (load_fire || out_fire) io_cnt <= io_cnt + ONE;
      if (load_fire && io_cnt == '0) inv_r <= in_inv;
      if (stage_end) begin
        bfly_cnt  <= '0;
        stage_cnt <= last_stage ? '0 : stage_cnt + SW'(1);
      end else if (issue) begin
        bfly_cnt <= bfly_cnt + ONE;
      end
      wb_valid <= issue;
      wb_a     <= addr_a;
      wb_c     <= addr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      buf_re[IW'(bitrev(int'(io_cnt), LOGN))] <= in_re;
      buf_im[IW'(bitrev(int'(io_cnt), LOGN))] <= in_im;
    end
    if (wb_valid) begin
      buf_re[wb_a] <= y0_re;
      buf_im[wb_a] <= y0_im;
      buf_re[wb_c] <= y1_re;
      buf_im[wb_c] <= y1_im;
    end
  end

  fft_butterfly #(.W(W), .SCALE(SCALE)) u_bfly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (issue),
    .inv   (inv_r),
    .a_re  (buf_re[addr_a]),
    .a_im  (buf_im[addr_a]),
    .c_re  (buf_re[addr_c]),
    .c_im  (buf_im[addr_c]),
    .w_cos (rom_cos[tw_idx]),
    .w_sin (rom_sin[tw_idx]),
    .y0_re (y0_re),
    .y0_im (y0_im),
    .y1_re (y1_re),
    .y1_im (y1_im)
  );

endmodule
